// File: rtl/io_glitch_filter_if.sv
// io_glitch_filter_if
//   Bundle of the filter's data/control inputs and conditioned outputs.
//   master : stimulus side (drives D, Threshold, Clr)
//   slave  : filter side (drives Qp, Qn, EdgeFlag, SpikeFlag, SpikeAny, SpikeCount)
interface io_glitch_filter_if #(
    parameter int CHANNELS    = 3,
    parameter int CNT_W       = 4,
    parameter int SPIKE_CNT_W = 8
);
    logic [CHANNELS-1:0]             D;
    logic [CNT_W-1:0]                Threshold;
    logic                            Clr;
    logic [CHANNELS-1:0]             Qp;
    logic [CHANNELS-1:0]             Qn;
    logic [CHANNELS-1:0]             EdgeFlag;
    logic [CHANNELS-1:0]             SpikeFlag;
    logic                            SpikeAny;
    logic [CHANNELS*SPIKE_CNT_W-1:0] SpikeCount;

    modport master (
        output D, Threshold, Clr,
        input  Qp, Qn, EdgeFlag, SpikeFlag, SpikeAny, SpikeCount
    );

    modport slave (
        input  D, Threshold, Clr,
        output Qp, Qn, EdgeFlag, SpikeFlag, SpikeAny, SpikeCount
    );
endinterface

// File: rtl/io_glitch_filter.sv
// io_glitch_filter
//   Multi-channel input conditioner: per channel a synchronizer chain feeding a
//   persistence filter. The output flips only after Teff consecutive samples
//   that differ from it; an aborted run is reported as a spike and counted in a
//   saturating per-channel counter.
//   Ports:
//     Clk  - system clock, rising edge
//     Rst  - synchronous active-high reset
//     bus  - io_glitch_filter_if.slave (D, Threshold, Clr in; Qp, Qn,
//            EdgeFlag, SpikeFlag, SpikeAny, SpikeCount out)

// Per-channel synchronizer + persistence filter.
module io_glitch_filter_ch #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4,
    parameter int SPIKE_CNT_W = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   d_i,
    input  logic [CNT_W-1:0]       teff_i,
    input  logic                   clr_i,
    output logic                   qp_o,
    output logic                   edge_o,
    output logic                   spike_o,
    output logic                   spike_d_o,
    output logic [SPIKE_CNT_W-1:0] count_o
);
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   q_q, q_d;
    logic [CNT_W-1:0]       run_q, run_d;
    logic                   edge_q, edge_d;
    logic                   spike_q, spike_d;
    logic [SPIKE_CNT_W-1:0] cnt_q, cnt_d;
    logic                   s;
    logic [CNT_W:0]         run_inc;

    always_comb begin
        sync_d[0] = d_i;
        for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    end

    assign s = sync_q[SYNC_STAGES-1];
    // One extra bit so run+1 can never wrap before the compare.
    assign run_inc = {1'b0, run_q} + (CNT_W+1)'(1);

    always_comb begin
        q_d     = q_q;
        run_d   = run_q;
        edge_d  = 1'b0;
        spike_d = 1'b0;
        cnt_d   = cnt_q;
        if (s != q_q) begin
            if (run_inc >= {1'b0, teff_i}) begin
                q_d    = s;
                run_d  = '0;
                edge_d = 1'b1;
            end else begin
                run_d = run_inc[CNT_W-1:0];
            end
        end else if (run_q != '0) begin
            // Input went back before the run completed: aborted transition.
            run_d   = '0;
            spike_d = 1'b1;
            if (cnt_q != '1) cnt_d = cnt_q + SPIKE_CNT_W'(1);
        end
        if (clr_i) cnt_d = '0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q  <= '0;
            q_q     <= 1'b0;
            run_q   <= '0;
            edge_q  <= 1'b0;
            spike_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            q_q     <= q_d;
            run_q   <= run_d;
            edge_q  <= edge_d;
            spike_q <= spike_d;
            cnt_q   <= cnt_d;
        end
    end

    assign qp_o      = q_q;
    assign edge_o    = edge_q;
    assign spike_o   = spike_q;
    assign spike_d_o = spike_d;
    assign count_o   = cnt_q;
endmodule

module io_glitch_filter #(
    parameter int CHANNELS    = 3,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 4,
    parameter int SPIKE_CNT_W = 8
) (
    input  logic              Clk,
    input  logic              Rst,
    io_glitch_filter_if.slave bus
);
    logic [CNT_W-1:0]                       teff;
    logic [CHANNELS-1:0]                    qp, edge_f, spike_f, spike_nxt;
    logic [CHANNELS-1:0][SPIKE_CNT_W-1:0]   cnt;
    logic                                   any_q;

    // Threshold 0 behaves as 1; taken live every cycle so changes apply mid-run.
    assign teff = (bus.Threshold == '0) ? CNT_W'(1) : bus.Threshold;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        io_glitch_filter_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .CNT_W       (CNT_W),
            .SPIKE_CNT_W (SPIKE_CNT_W)
        ) u_ch (
            .clk_i     (Clk),
            .rst_i     (Rst),
            .d_i       (bus.D[g]),
            .teff_i    (teff),
            .clr_i     (bus.Clr),
            .qp_o      (qp[g]),
            .edge_o    (edge_f[g]),
            .spike_o   (spike_f[g]),
            .spike_d_o (spike_nxt[g]),
            .count_o   (cnt[g])
        );
    end

    // Registered from the per-channel next-state so it lines up with SpikeFlag.
    always_ff @(posedge Clk) begin
        if (Rst) any_q <= 1'b0;
        else     any_q <= |spike_nxt;
    end

    assign bus.Qp         = qp;
    assign bus.Qn         = ~qp;
    assign bus.EdgeFlag   = edge_f;
    assign bus.SpikeFlag  = spike_f;
    assign bus.SpikeAny   = any_q;
    assign bus.SpikeCount = cnt;
endmodule

// File: tb/tb_io_glitch_filter.sv
module tb_io_glitch_filter;
    logic Clk;
    logic Rst;
    int   checks;
    int   failures;

    io_glitch_filter_if #(.CHANNELS(3), .CNT_W(4), .SPIKE_CNT_W(8)) bus ();

    io_glitch_filter #(
        .CHANNELS(3), .SYNC_STAGES(2), .CNT_W(4), .SPIKE_CNT_W(8)
    ) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_out(input string tag, input logic [2:0] qp, input logic [2:0] ef,
                              input logic [2:0] sf, input logic [23:0] cnt);
        chk({tag, ".Qp"},         {29'd0, bus.Qp},        {29'd0, qp});
        chk({tag, ".Qn"},         {29'd0, bus.Qn},        {29'd0, ~qp});
        chk({tag, ".EdgeFlag"},   {29'd0, bus.EdgeFlag},  {29'd0, ef});
        chk({tag, ".SpikeFlag"},  {29'd0, bus.SpikeFlag}, {29'd0, sf});
        chk({tag, ".SpikeAny"},   {31'd0, bus.SpikeAny},  {31'd0, |sf});
        chk({tag, ".SpikeCount"}, {8'd0, bus.SpikeCount}, {8'd0, cnt});
    endtask

    initial begin
        checks = 0;
        failures = 0;
        Rst = 1'b1;
        bus.D = 3'b000;
        bus.Threshold = 4'd5;
        bus.Clr = 1'b0;

        // Reset state, then 20 idle cycles
        tick(2);
        expect_out("reset", 3'b000, 3'b000, 3'b000, 24'h0);
        Rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick(1);
            expect_out($sformatf("idle%0d", i), 3'b000, 3'b000, 3'b000, 24'h0);
        end

        // Threshold 5: ch0 rises 6 edges after first capture
        bus.D = 3'b001;
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            expect_out($sformatf("rise_wait%0d", i), 3'b000, 3'b000, 3'b000, 24'h0);
        end
        tick(1);
        expect_out("rise_flip", 3'b001, 3'b001, 3'b000, 24'h0);
        tick(1);
        expect_out("rise_after", 3'b001, 3'b000, 3'b000, 24'h0);

        // 3-cycle pulse on ch1: spike at W+2 edges after first capture
        bus.D = 3'b011;
        tick(3);
        bus.D = 3'b001;
        tick(2);
        expect_out("spike_pre", 3'b001, 3'b000, 3'b000, 24'h0);
        tick(1);
        expect_out("spike_hit", 3'b001, 3'b000, 3'b010, 24'h000100);
        tick(1);
        expect_out("spike_post", 3'b001, 3'b000, 3'b000, 24'h000100);
        for (int i = 0; i < 299; i++) begin
            bus.D = 3'b011;
            tick(3);
            bus.D = 3'b001;
            tick(4);
        end
        expect_out("spike_300", 3'b001, 3'b000, 3'b000, 24'h00FF00);
        bus.D = 3'b011;
        tick(3);
        bus.D = 3'b001;
        tick(3);
        expect_out("spike_sat", 3'b001, 3'b000, 3'b010, 24'h00FF00);
        tick(1);

        // Threshold 0 and 1: single-cycle pulse on ch2 passes through
        for (int t = 0; t < 2; t++) begin
            bus.Threshold = 4'(t);
            tick(2);
            bus.D = 3'b101;
            tick(1);
            bus.D = 3'b001;
            tick(1);
            expect_out($sformatf("thr%0d_k1", t), 3'b001, 3'b000, 3'b000, 24'h00FF00);
            tick(1);
            expect_out($sformatf("thr%0d_up", t), 3'b101, 3'b100, 3'b000, 24'h00FF00);
            tick(1);
            expect_out($sformatf("thr%0d_dn", t), 3'b001, 3'b100, 3'b000, 24'h00FF00);
            tick(1);
            expect_out($sformatf("thr%0d_end", t), 3'b001, 3'b000, 3'b000, 24'h00FF00);
        end

        // Threshold lowered 8 -> 2 after 3 mismatched samples
        bus.Threshold = 4'd8;
        bus.D = 3'b011;
        tick(5);
        expect_out("mid_run", 3'b001, 3'b000, 3'b000, 24'h00FF00);
        bus.Threshold = 4'd2;
        tick(1);
        expect_out("mid_flip", 3'b011, 3'b010, 3'b000, 24'h00FF00);
        bus.D = 3'b001;
        tick(6);
        expect_out("mid_back", 3'b001, 3'b000, 3'b000, 24'h00FF00);

        // Clr coinciding with a spike on ch2
        bus.Threshold = 4'd5;
        bus.D = 3'b101;
        tick(2);
        bus.D = 3'b001;
        tick(2);
        bus.Clr = 1'b1;
        tick(1);
        expect_out("clr_spike", 3'b001, 3'b000, 3'b100, 24'h0);
        bus.Clr = 1'b0;
        tick(1);
        expect_out("clr_after", 3'b001, 3'b000, 3'b000, 24'h0);

        // Reset mid-run with Qp[0]=1, then a short pulse counts from zero
        bus.D = 3'b011;
        tick(3);
        Rst = 1'b1;
        tick(1);
        expect_out("rst_mid", 3'b000, 3'b000, 3'b000, 24'h0);
        bus.D = 3'b000;
        tick(1);
        Rst = 1'b0;
        tick(3);
        expect_out("rst_idle", 3'b000, 3'b000, 3'b000, 24'h0);
        bus.D = 3'b010;
        tick(4);
        bus.D = 3'b000;
        tick(2);
        expect_out("rst_pulse_pre", 3'b000, 3'b000, 3'b000, 24'h0);
        tick(1);
        expect_out("rst_pulse_spike", 3'b000, 3'b000, 3'b010, 24'h000100);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
